// File: rtl/collector_arbiter.sv
// rtl/collector_arbiter.sv - round-robin arbiter sharing one packet collector among local ports
module collector_arbiter #(
  parameter int dataWidth = 32,
  parameter int NUM_PORTS = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PORTS-1:0]           ReqUpStr,
  input  logic [NUM_PORTS*dataWidth-1:0] PacketIn,
  output logic [NUM_PORTS-1:0]           GntUpStr,
  output logic                           ReqDnStr,
  output logic [dataWidth-1:0]           PacketOut,
  input  logic                           GntDnStr,
  input  logic                           DnStrFull,
  output logic [15:0]                    GrantCount,
  output logic                           TimeoutErr
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_GNT  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]        winner_q, winner_d;
  logic [7:0]           wait_cnt_q, wait_cnt_d;
  logic [NUM_PORTS-1:0] gnt_q, gnt_d;
  logic                 req_q, req_d;
  logic                 tmo_q, tmo_d;
  logic [dataWidth-1:0] pkt_q, pkt_d;
  logic [15:0]          grant_cnt_q, grant_cnt_d;

  logic                 found;
  logic [PW-1:0]        pick;
  logic [PW-1:0]        idx;
  logic [PW-1:0]        winner_inc;

  // First asserted request at or after rr_ptr, wrapping modulo NUM_PORTS.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = PW'((int'(rr_ptr_q) + k) % NUM_PORTS);
      if (!found && ReqUpStr[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign winner_inc = (winner_q == PW'(NUM_PORTS - 1)) ? '0 : winner_q + PW'(1);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    winner_d    = winner_q;
    wait_cnt_d  = wait_cnt_q;
    gnt_d       = '0;
    req_d       = req_q;
    tmo_d       = 1'b0;
    pkt_d       = pkt_q;
    grant_cnt_d = grant_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (found && !DnStrFull && !GntDnStr) begin
          winner_d   = pick;
          pkt_d      = PacketIn[pick*dataWidth +: dataWidth];
          req_d      = 1'b1;
          wait_cnt_d = '0;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        // A collector grant wins over a timeout landing on the same cycle.
        if (GntDnStr) begin
          req_d           = 1'b0;
          gnt_d[winner_q] = 1'b1;
          grant_cnt_d     = grant_cnt_q + 16'd1;
          rr_ptr_d        = winner_inc;
          state_d         = S_GNT;
        end else if (wait_cnt_q == 8'(TIMEOUT - 1)) begin
          req_d    = 1'b0;
          tmo_d    = 1'b1;
          rr_ptr_d = winner_inc;
          state_d  = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_GNT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      winner_q    <= '0;
      wait_cnt_q  <= '0;
      gnt_q       <= '0;
      req_q       <= 1'b0;
      tmo_q       <= 1'b0;
      pkt_q       <= '0;
      grant_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      winner_q    <= winner_d;
      wait_cnt_q  <= wait_cnt_d;
      gnt_q       <= gnt_d;
      req_q       <= req_d;
      tmo_q       <= tmo_d;
      pkt_q       <= pkt_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign GntUpStr   = gnt_q;
  assign ReqDnStr   = req_q;
  assign TimeoutErr = tmo_q;
  assign PacketOut  = pkt_q;
  assign GrantCount = grant_cnt_q;

endmodule

// File: tb/tb_collector_arbiter.sv
// tb/tb_collector_arbiter.sv - directed and randomized checks of collector_arbiter against a timeline model
module tb_collector_arbiter;
  localparam int TMO = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [127:0] pkt_bus;
  logic         full;
  logic         gnt_dn;
  logic [3:0]   gnt_up;
  logic         req_dn;
  logic [31:0]  pkt_out;
  logic [15:0]  gcount;
  logic         tmo;

  int total = 0;
  int bad = 0;
  int edge_n = 0;

  // Reference model state: transfer timeline expressed as edge numbers.
  int          m_ptr = 0;
  int          m_win = 0;
  int          m_start = 0;
  int          m_ready = 0;
  bit          m_busy = 1'b0;
  logic [15:0] m_cnt = '0;
  logic [31:0] m_pkt = '0;
  logic [3:0]  e_gnt = '0;
  logic        e_req = 1'b0;
  logic        e_tmo = 1'b0;

  // Collector responder and upstream port behaviour.
  bit         c_en = 1'b1;
  int         c_lat = 1;
  int         c_age = 0;
  bit         auto_drop = 1'b1;
  logic [3:0] dropped = '0;

  collector_arbiter #(.dataWidth(32), .NUM_PORTS(4), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .ReqUpStr  (req),
    .PacketIn  (pkt_bus),
    .GntUpStr  (gnt_up),
    .ReqDnStr  (req_dn),
    .PacketOut (pkt_out),
    .GntDnStr  (gnt_dn),
    .DnStrFull (full),
    .GrantCount(gcount),
    .TimeoutErr(tmo)
  );

  always #5 clk = ~clk;

  function automatic int rr_pick(logic [3:0] m, int p);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (p + k) % 4;
      if (m[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [3:0]   r_s;
    logic [127:0] p_s;
    logic         f_s, g_s, rst_s;
    r_s = req; p_s = pkt_bus; f_s = full; g_s = gnt_dn; rst_s = reset;
    @(posedge clk);
    edge_n++;
    e_gnt = '0;
    e_tmo = 1'b0;
    if (rst_s) begin
      m_busy = 1'b0; m_ptr = 0; m_cnt = '0; m_pkt = '0; e_req = 1'b0; m_ready = 0;
    end else if (m_busy) begin
      if (g_s) begin
        e_gnt = 4'b0001 << m_win;
        e_req = 1'b0;
        m_cnt = m_cnt + 16'd1;
        m_ptr = (m_win + 1) % 4;
        m_busy = 1'b0;
        m_ready = edge_n + 2;
      end else if (edge_n - m_start == TMO) begin
        e_tmo = 1'b1;
        e_req = 1'b0;
        m_ptr = (m_win + 1) % 4;
        m_busy = 1'b0;
        m_ready = edge_n + 1;
      end
    end else if (edge_n >= m_ready && r_s != 4'b0 && !f_s && !g_s) begin
      m_win = rr_pick(r_s, m_ptr);
      m_pkt = p_s[m_win*32 +: 32];
      m_busy = 1'b1;
      m_start = edge_n;
      e_req = 1'b1;
    end
    #1;
    check("gnt_up", 32'(gnt_up), 32'(e_gnt));
    check("req_dn", 32'(req_dn), 32'(e_req));
    check("timeout_err", 32'(tmo), 32'(e_tmo));
    check("grant_count", 32'(gcount), 32'(m_cnt));
    check("packet_out", pkt_out, m_pkt);
    gnt_dn = c_en && (c_age >= c_lat);
    c_age = req_dn ? c_age + 1 : 0;
    if (auto_drop) begin
      dropped = gnt_up;
      req = req & ~gnt_up;
    end
  endtask

  task automatic run_until_grant(int max, output int port, output int ed);
    port = -1;
    ed = -1;
    for (int i = 0; i < max; i++) begin
      step();
      if (gnt_up != 4'b0) begin
        for (int k = 0; k < 4; k++) if (gnt_up[k[1:0]]) port = k;
        ed = edge_n;
        break;
      end
    end
    check("grant_wait", 32'(port >= 0), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; full = 1'b0; c_en = 1'b1; c_lat = 1;
    step(); step();
    reset = 1'b0;
  endtask

  initial begin
    int port, ed, prev, w0, hi, tmo_n;
    bit gnt_any;
    reset = 1'b1; req = '0; pkt_bus = '0; full = 1'b0; gnt_dn = 1'b0;
    step(); step();
    check("rst_gnt_up", 32'(gnt_up), 32'd0);
    check("rst_req_dn", 32'(req_dn), 32'd0);
    check("rst_count", 32'(gcount), 32'd0);
    reset = 1'b0;

    // Single request from port 2.
    pkt_bus = {$urandom, $urandom, $urandom, $urandom};
    pkt_bus[64 +: 32] = 32'h0000_ABCD;
    req = 4'b0100;
    w0 = edge_n;
    run_until_grant(12, port, ed);
    check("t1_port", port, 2);
    check("t1_latency", ed - w0, 3);
    check("t1_packet", pkt_out, 32'h0000_ABCD);
    check("t1_count", 32'(gcount), 32'd1);
    step();
    check("t1_pulse_len", 32'(gnt_up), 32'd0);
    step(); step();
    req = 4'b1001;
    run_until_grant(12, port, ed);
    check("t1_next_ptr", port, 3);

    // All four ports requesting continuously.
    do_reset();
    auto_drop = 1'b0;
    pkt_bus = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
    req = 4'hF;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      run_until_grant(12, port, ed);
      check("t2_order", port, i % 4);
      check("t2_packet", pkt_out, pkt_bus[(i % 4)*32 +: 32]);
      if (i > 0) check("t2_spacing", ed - prev, 4);
      check("t2_count", 32'(gcount), i + 1);
      prev = ed;
    end
    auto_drop = 1'b1;

    // Collector never grants.
    do_reset();
    c_en = 1'b0;
    req = 4'b0010;
    hi = 0; tmo_n = 0; gnt_any = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      hi += int'(req_dn);
      gnt_any |= (gnt_up != 4'b0);
      if (tmo) begin
        tmo_n++;
        break;
      end
    end
    check("t3_req_high", hi, TMO);
    check("t3_timeout_seen", tmo_n, 1);
    check("t3_no_grant", 32'(gnt_any), 32'd0);
    step();
    check("t3_pulse_len", 32'(tmo), 32'd0);
    check("t3_retry", 32'(req_dn), 32'd1);
    c_en = 1'b1;
    run_until_grant(20, port, ed);
    check("t3_retry_port", port, 1);

    // Collector full blocks new starts.
    do_reset();
    full = 1'b1;
    req = 4'b1001;
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      hi += int'(req_dn);
    end
    check("t4_blocked", hi, 0);
    full = 1'b0;
    step();
    check("t4_start", 32'(req_dn), 32'd1);
    run_until_grant(10, port, ed);
    check("t4_port", port, 0);

    // Reset in REQ on the same cycle the collector grants.
    do_reset();
    req = 4'b0001;
    step();
    check("t5_in_req", 32'(req_dn), 32'd1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_gnt_up", 32'(gnt_up), 32'd0);
    check("t5_req_dn", 32'(req_dn), 32'd0);
    check("t5_count", 32'(gcount), 32'd0);
    check("t5_packet", pkt_out, 32'd0);

    // GrantCount wrap.
    do_reset();
    step(); step();
    force dut.grant_cnt_q = 16'hFFFF;
    #1;
    release dut.grant_cnt_q;
    m_cnt = 16'hFFFF;
    req = 4'b0100;
    run_until_grant(12, port, ed);
    check("t6_wrap", 32'(gcount), 32'd0);

    // Randomized traffic, collector latency and backpressure.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req[i[1:0]] && !dropped[i[1:0]] && $urandom_range(3) == 0) begin
          req[i[1:0]] = 1'b1;
          pkt_bus[i*32 +: 32] = $urandom;
        end
      end
      full = ($urandom_range(7) == 0);
      if (!req_dn && c_age == 0) begin
        c_lat = $urandom_range(5, 1);
        c_en = ($urandom_range(5) != 0);
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
